sevseg_capture: RTL and testbench
=================================

Name: sevseg_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment driver.
- Samples the active-low segment bus and the active-low anode bus, waits for each digit slot to settle, and decodes each segment pattern back to a BCD digit.
- Assembles the ones, tens, hundreds and thousands digits into one frame and publishes the decimal value in binary and BCD.
- Used as a loopback checker and as the readback path for the display bus in the lab top level.

Parameters:
SETTLE_CYCLES, 16, consecutive identical synchronized samples required before a digit is captured (min 2)
TIMEOUT_CYCLES, 1_000_000, cycles without a good frame before stale asserts

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
seg  input  [0:6]  active-low segments; seg[0]=a (MSB of pattern) ... seg[6]=g
digit  input  4  active-low anodes; digit[0]=ones, digit[1]=tens, digit[2]=hundreds, digit[3]=thousands
number  output  14  binary value 0..9999 of last good frame
bcd  output  16  {thousands,hundreds,tens,ones} of last good frame
frame_valid  output  1  one-cycle pulse when number/bcd update
digit_err  output  1  one-cycle pulse when a completed frame held an undecodable pattern
stale  output  1  high while no good frame within TIMEOUT_CYCLES

Behaviour:
- Reset values: number=0, bcd=0, frame_valid=0, digit_err=0, stale=0. Slot mask=0, error flag=0, all counters=0, dwell FSM=WAIT. Synchronizer flops load all-ones (blank, anodes off).
- Input: two-flop synchronizer on {digit,seg}. All logic below uses the synchronized values.
- Anode valid: exactly one digit bit is 0. Slot = index of that bit.
- Decode (seg[0:6] -> digit): 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9. Any other pattern is a decode error.
- Dwell FSM states and transitions:
  - WAIT: leave when the anode is valid. Go to SETTLE with stable count=1.
  - SETTLE: if {digit,seg} differs from the previous cycle, go to SETTLE with count=1 when the anode is valid, else to WAIT. Otherwise increment the count. When the count reaches SETTLE_CYCLES, capture the decoded digit into its slot, set the slot's mask bit, OR any decode error into the error flag, and go to HOLD.
  - HOLD: no further captures. On any change, go to SETTLE (count=1) when the anode is valid, else to WAIT.
- Exactly one capture per dwell. A glitch shorter than SETTLE_CYCLES is never captured.
- A recaptured slot whose mask bit is already set is overwritten (newest wins). Its error contribution stays ORed into the error flag.
- Commit happens on the cycle after the capture that makes mask==4'b1111:
  - Error flag clear: number = thousands*1000 + hundreds*100 + tens*10 + ones (registered), bcd updates, frame_valid=1 for one cycle.
  - Error flag set: digit_err=1 for one cycle; number and bcd are held.
  - In both cases, mask and error flag clear in the same cycle.
- Latency: frame_valid rises exactly SETTLE_CYCLES+3 clocks after the edge on which the pins first present the completing digit. This is 2 cycles of sync, SETTLE_CYCLES-1 cycles of counting, 1 cycle of capture and 1 cycle of commit.
- Stale: counter clears on frame_valid and saturates at TIMEOUT_CYCLES. stale=1 while the counter equals TIMEOUT_CYCLES. stale clears in the same cycle frame_valid asserts. digit_err does not clear the counter.
- A capture and a commit in the same cycle is legal: the capture belongs to the next frame, because the mask clears before the new bit is set.
- A thousands pattern of 0000100 decodes as 9. A transmitter showing a value above 9999 therefore reads back as 9xxx and raises no error.
- Reset mid-frame discards partial slots. The next frame needs all four slots again.

Test Plan:
- SETTLE_CYCLES=4; scan 1234 with a 20-cycle dwell per slot -> one frame_valid after the thousands slot, number=1234, bcd=16'h1234, digit_err=0. frame_valid rises exactly 7 clocks after the thousands pattern first appears on the pins.
- Same scan with a 2-cycle 1111111 glitch between each pair of digits -> glitches not captured, number=1234.
- Steady scan of 1234 until its frame commits, then the next frame has tens pattern 1111111 -> digit_err pulses once, no frame_valid, number stays 1234. The following clean scan of 5678 -> number=5678.
- digit=4'b1100 held 50 cycles, then the normal 0000 scan -> no capture during the double-anode period, result number=0 with frame_valid.
- TIMEOUT_CYCLES=100; scan 9999 then stop -> stale=1 exactly 100 cycles after frame_valid. Resume the scan -> stale=0 on the next frame_valid.
- reset asserted after 2 slots are captured; release, then scan 4321 -> no frame_valid until all four new slots are captured, then number=4321.

Source files
------------

// File: rtl/sevseg_capture.sv
// Receive side of a multiplexed 4-digit seven-segment bus: waits for each digit
// slot to settle, decodes it back to BCD and publishes complete frames.
module sevseg_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:6]  seg,
    input  logic [3:0]  digit,
    output logic [13:0] number,
    output logic [15:0] bcd,
    output logic        frame_valid,
    output logic        digit_err,
    output logic        stale
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0]  TIMEOUT_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

    logic [10:0]      sync1_q, sync2_q, prev_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      digits_q;
    logic [3:0]       mask_q, mask_d;
    logic             err_q, err_d;
    logic [13:0]      number_q;
    logic [15:0]      bcd_q;
    logic             frame_valid_q, digit_err_q;
    logic [TO_W-1:0]  stale_cnt_q;

    logic [3:0]  sync_digit;
    logic [6:0]  sync_seg;
    logic        anode_valid, changed, capture, commit;
    logic [1:0]  slot;
    logic [3:0]  dec_val;
    logic        dec_err;
    logic [13:0] frame_value;

    assign sync_digit = sync2_q[10:7];
    assign sync_seg   = sync2_q[6:0];
    assign changed    = (sync2_q != prev_q);
    assign commit     = (mask_q == 4'b1111);

    always_comb begin
        anode_valid = 1'b1;
        slot        = 2'd0;
        case (sync_digit)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: anode_valid = 1'b0;
        endcase
    end

    always_comb begin
        dec_val = 4'd0;
        dec_err = 1'b0;
        case (sync_seg)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            default:    dec_err = 1'b1;
        endcase
    end

    // One capture per dwell: the count only ever reaches the limit once before HOLD.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (anode_valid) begin
                    state_d = ST_SETTLE;
                    count_d = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (changed) begin
                    state_d = anode_valid ? ST_SETTLE : ST_WAIT;
                    count_d = CNT_W'(1);
                end else if (count_q == SETTLE_MAX) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    state_d = anode_valid ? ST_SETTLE : ST_WAIT;
                    count_d = CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT;
                count_d = '0;
            end
        endcase
    end

    // The mask clears on commit before a same-cycle capture sets its bit,
    // so that capture starts the next frame.
    always_comb begin
        mask_d = commit ? 4'b0000 : mask_q;
        err_d  = commit ? 1'b0 : err_q;
        if (capture) begin
            mask_d = mask_d | (4'b0001 << slot);
            err_d  = err_d | dec_err;
        end
    end

    assign frame_value = 14'(digits_q[15:12]) * 14'd1000 + 14'(digits_q[11:8]) * 14'd100
                       + 14'(digits_q[7:4]) * 14'd10 + 14'(digits_q[3:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            state_q       <= ST_WAIT;
            count_q       <= '0;
            digits_q      <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            number_q      <= '0;
            bcd_q         <= '0;
            frame_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            stale_cnt_q   <= '0;
        end else begin
            sync1_q       <= {digit, seg};
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            state_q       <= state_d;
            count_q       <= count_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            frame_valid_q <= commit & ~err_q;
            digit_err_q   <= commit & err_q;
            for (int i = 0; i < 4; i++) begin
                if (capture && (slot == 2'(i)))
                    digits_q[i*4 +: 4] <= dec_val;
            end
            if (commit && !err_q) begin
                number_q    <= frame_value;
                bcd_q       <= digits_q;
                stale_cnt_q <= '0;
            end else if (stale_cnt_q != TIMEOUT_MAX) begin
                stale_cnt_q <= stale_cnt_q + TO_W'(1);
            end
        end
    end

    assign number      = number_q;
    assign bcd         = bcd_q;
    assign frame_valid = frame_valid_q;
    assign digit_err   = digit_err_q;
    assign stale       = (stale_cnt_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_sevseg_capture.sv
// Bench for sevseg_capture: a run-length model of the display bus predicts every
// output each cycle; literal checks pin the model on the documented scenarios.
module tb_sevseg_capture;

    localparam int S = 4;
    localparam int T = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:6]  seg;
    logic [3:0]  digit;
    logic [13:0] number;
    logic [15:0] bcd;
    logic        frame_valid, digit_err, stale;

    always #5 clk = ~clk;

    sevseg_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .seg(seg), .digit(digit),
        .number(number), .bcd(bcd), .frame_valid(frame_valid),
        .digit_err(digit_err), .stale(stale)
    );

    logic [6:0] enc_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          due;
        bit          good;
        int          value;
        logic [15:0] bcd;
    } ev_t;
    ev_t ev_q[$];

    int          cyc = 0;
    logic [10:0] run_val;
    int          run_len;
    int          m_dig [4];
    logic [3:0]  m_mask;
    bit          m_err;
    int          m_num;
    logic [15:0] m_bcd;
    bit          m_fv, m_de;
    int          m_stale_cnt;

    int fv_count = 0, de_count = 0, last_fv_cyc = 0, stale_rise_cyc = 0;
    bit stale_prev = 1'b0;
    int thou_cyc = 0;

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (enc_tab[i] == p) return i;
        return -1;
    endfunction

    // Model: a digit is taken once a valid-anode value has been sampled S+1 times in a row;
    // the pipeline puts the result on the outputs three clocks after that sample.
    always @(posedge clk) begin
        logic [10:0] cur;
        int sl, dv;
        ev_t e;
        cyc++;
        cur = {digit, seg};
        if (reset) begin
            run_val = 11'h7FF; run_len = 1;
            m_mask = 4'h0; m_err = 1'b0;
            m_num = 0; m_bcd = 16'h0; m_fv = 1'b0; m_de = 1'b0; m_stale_cnt = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            ev_q.delete();
        end else begin
            m_fv = 1'b0; m_de = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
                e = ev_q.pop_front();
                if (e.good) begin m_fv = 1'b1; m_num = e.value; m_bcd = e.bcd; end
                else m_de = 1'b1;
            end
            if (m_fv) m_stale_cnt = 0;
            else if (m_stale_cnt < T) m_stale_cnt++;
            if (cur == run_val) run_len++;
            else begin run_val = cur; run_len = 1; end
            if (run_len == S + 1 && $countones(~cur[10:7]) == 1) begin
                sl = 0;
                for (int i = 0; i < 4; i++) if (!cur[7+i]) sl = i;
                dv = decode(cur[6:0]);
                if (dv < 0) m_err = 1'b1;
                else m_dig[sl] = dv;
                m_mask[sl] = 1'b1;
                if (m_mask == 4'hF) begin
                    e.due   = cyc + 3;
                    e.good  = !m_err;
                    e.value = m_dig[3]*1000 + m_dig[2]*100 + m_dig[1]*10 + m_dig[0];
                    e.bcd   = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
                    ev_q.push_back(e);
                    m_mask = 4'h0; m_err = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            vectors++;
            if (number !== 14'(m_num) || bcd !== m_bcd || frame_valid !== m_fv ||
                digit_err !== m_de || stale !== (m_stale_cnt == T)) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got num=%0d bcd=%h fv=%b de=%b stale=%b expected num=%0d bcd=%h fv=%b de=%b stale=%b",
                         cyc, number, bcd, frame_valid, digit_err, stale,
                         m_num, m_bcd, m_fv, m_de, (m_stale_cnt == T));
            end
            if (frame_valid === 1'b1) begin fv_count++; last_fv_cyc = cyc; end
            if (digit_err === 1'b1) de_count++;
            if (stale === 1'b1 && !stale_prev) stale_rise_cyc = cyc;
            stale_prev = (stale === 1'b1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic [6:0] p, input int n);
        digit = d;
        seg   = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int slot, input logic [6:0] p, input int n);
        logic [3:0] d;
        d = 4'hF;
        d[slot] = 1'b0;
        drive(d, p, n);
    endtask

    task automatic scan(input int value, input int dwell, input bit glitch);
        int v;
        v = value;
        for (int sl = 0; sl < 4; sl++) begin
            if (sl == 3) thou_cyc = cyc;
            show(sl, enc_tab[v % 10], dwell);
            if (glitch && sl < 3) show(sl + 1, 7'b1111111, 2);
            v = v / 10;
        end
    endtask

    initial begin
        int fv0, de0, val, kind;
        reset = 1'b1; seg = 7'h7F; digit = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset_number", int'(number), 0);
        chk("reset_stale", int'(stale), 0);
        reset = 1'b0;

        fv0 = fv_count; de0 = de_count;
        scan(1234, 20, 1'b0);
        #2;
        chk("scan1234_fv_count", fv_count - fv0, 1);
        chk("scan1234_de_count", de_count - de0, 0);
        chk("scan1234_number", int'(number), 1234);
        chk("scan1234_bcd", int'(bcd), 'h1234);
        chk("scan1234_latency", last_fv_cyc - (thou_cyc + 1), 7);

        fv0 = fv_count;
        scan(1234, 20, 1'b1);
        #2;
        chk("glitch_fv_count", fv_count - fv0, 1);
        chk("glitch_number", int'(number), 1234);

        scan(1234, 20, 1'b0);
        fv0 = fv_count; de0 = de_count;
        show(0, enc_tab[4], 20);
        show(1, 7'b1111111, 20);
        show(2, enc_tab[2], 20);
        show(3, enc_tab[1], 20);
        #2;
        chk("err_de_count", de_count - de0, 1);
        chk("err_fv_count", fv_count - fv0, 0);
        chk("err_number_held", int'(number), 1234);
        scan(5678, 20, 1'b0);
        #2;
        chk("after_err_number", int'(number), 5678);

        fv0 = fv_count;
        drive(4'b1100, enc_tab[0], 50);
        #2;
        chk("double_anode_no_fv", fv_count - fv0, 0);
        scan(0, 20, 1'b0);
        #2;
        chk("zero_fv_count", fv_count - fv0, 1);
        chk("zero_number", int'(number), 0);

        scan(9999, 20, 1'b0);
        drive(4'hF, 7'h7F, 120);
        #2;
        chk("stale_high", int'(stale), 1);
        chk("stale_delay", stale_rise_cyc - last_fv_cyc, 100);
        scan(9999, 20, 1'b0);
        #2;
        chk("stale_cleared", int'(stale), 0);
        chk("stale_clear_with_fv", last_fv_cyc > stale_rise_cyc ? 1 : 0, 1);

        show(2, enc_tab[3], 20);
        show(3, enc_tab[8], 20);
        drive(4'hF, 7'h7F, 6);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drive(4'hF, 7'h7F, 4);
        fv0 = fv_count;
        scan(4321, 20, 1'b0);
        #2;
        chk("post_reset_fv_count", fv_count - fv0, 1);
        chk("post_reset_number", int'(number), 4321);

        for (int r = 0; r < 8; r++) begin
            val = int'($urandom_range(0, 9999));
            scan(val, int'($urandom_range(S + 1, 15)), 1'($urandom_range(0, 1)));
            drive(4'hF, 7'h7F, 5);
            #2;
            chk("random_scan_number", int'(number), val);
        end

        for (int r = 0; r < 400; r++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 8)
                show(int'($urandom_range(0, 3)), enc_tab[$urandom_range(0, 9)], int'($urandom_range(1, 12)));
            else if (kind == 8)
                show(int'($urandom_range(0, 3)), 7'($urandom), int'($urandom_range(1, 12)));
            else
                drive(4'($urandom), 7'($urandom), int'($urandom_range(1, 12)));
        end
        drive(4'hF, 7'h7F, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
